mem36_arbiter: RTL and testbench
================================

Name: mem36_arbiter

Overview:
- Shares one 36-bit single-ported, registered-read memory (32 data bits plus 4 tag bits, byte write mask on the data bits only) between two requesters: port A (instruction fetch) and port B (load/store).
- Arbitrates each cycle, drives the memory port, and routes the one-cycle-late read data back to the requester that issued the read.
- Policy is configurable: round-robin, or fixed priority to A with a starvation bound for B.

Parameters:
- WIDTH, 13: word-address width. Matches the memory depth of 2^WIDTH words.
- PRIO_A, 0: arbitration policy. 0 = round-robin. 1 = A has fixed priority, with the B starvation guard enabled.
- MAX_WAIT, 4: used only when PRIO_A=1. Number of consecutive cycles B may be refused while requesting before it is forced through. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- a_valid  in  1  port A request.
- a_ready  out  1  port A request granted this cycle (combinational).
- a_write  in  1  1 = write, 0 = read.
- a_wmask  in  4  byte enables for a_wdata[31:0].
- a_wdata  in  36  write data. Bits [35:32] are always written on a write.
- a_addr  in  WIDTH  word address.
- a_rvalid  out  1  read response for A (registered).
- a_rdata  out  36  read data for A.
- b_valid, b_ready, b_write, b_wmask, b_wdata, b_addr, b_rvalid, b_rdata: same as the A ports, for port B.
- mem_valid  out  1  memory access strobe.
- mem_write  out  1  memory write enable.
- mem_wmask  out  4  memory byte mask.
- mem_wdata  out  36  memory write data.
- mem_addr  out  WIDTH  memory address.
- mem_rdata  in  36  memory read data, valid one cycle after the address is presented.

Behaviour:
- Handshake
  - A request transfers when valid && ready in the same cycle.
  - Requesters hold all request fields stable while valid && !ready.
  - ready depends on the valid inputs and internal state only. It never depends on ready, and there is no combinational path from mem_rdata to any ready.
  - No response stall exists. Requesters accept rvalid unconditionally.
- Grant, round-robin (PRIO_A=0)
  - One-bit register last (0 = A, 1 = B).
  - Only one port requests: that port is granted.
  - Both request: grant A if last=1, else grant B.
  - last updates to the granted port on every grant; otherwise it holds.
- Grant, priority (PRIO_A=1)
  - A wins whenever a_valid=1, except as below.
  - 4-bit counter wait_b increments (saturating at MAX_WAIT) each cycle b_valid && !b_ready, and clears on a B grant or when b_valid=0.
  - When wait_b == MAX_WAIT and b_valid=1, B is granted regardless of A.
- Memory drive
  - On grant, mem_valid=1 and mem_write/mem_wmask/mem_wdata/mem_addr come from the granted port in the same cycle (zero added latency).
  - No grant: mem_valid=0, mem_write=0, mem_wmask=0. mem_addr and mem_wdata carry A's fields.
- Response routing
  - Registered flags rd_a and rd_b are set at the clock edge of a granted read (write=0) for the respective port. Both are cleared otherwise.
  - a_rvalid = rd_a and a_rdata = mem_rdata, in the cycle following the grant. B is the same with rd_b.
  - rdata outputs are don't-care while the matching rvalid=0. The bench checks rdata only with rvalid=1.
- Writes produce no response.
  - A granted write to address X followed immediately by a granted read of X returns the new data: the read samples memory after the write edge.
- Latency and throughput
  - Read latency is exactly 1 cycle from the grant edge.
  - Back-to-back grants are allowed every cycle, alternating or not, with a peak throughput of one access per cycle.
- Reset
  - rstn=0 clears at once: last=0, wait_b=0, rd_a=rd_b=0, so a_rvalid=b_rvalid=0.
  - a_ready/b_ready follow the combinational rule. While rstn=0 they are forced to 0 and mem_valid=0.
  - A read granted in the cycle before reset asserts gets no response; it is dropped.
- Simultaneous events
  - A grant and a response to the other port in the same cycle are independent.
  - Only one port is ready in any cycle.

Test Plan:
- Reset, then A writes addr 0x010, wdata 0xF_DEADBEEF, wmask 0xF; next cycle A reads 0x010 -> a_rvalid=1 exactly one cycle later with a_rdata=0xF_DEADBEEF; b_rvalid stays 0.
- Partial write: B writes 0x010 with wdata 0x3_00000011, wmask 0x1, then reads 0x010 -> b_rdata=0x3_DEADBE11 (tag bits updated despite the mask).
- PRIO_A=0, both ports read continuously for 8 cycles -> grants alternate A,B,A,B… starting with B after reset (last=0); each port receives 4 responses, each one cycle after its grant.
- PRIO_A=1, MAX_WAIT=4, A and B both request continuously -> A granted 4 cycles, B granted on the 5th, pattern repeats; b_ready is never low for more than 4 consecutive requesting cycles.
- Grant a B read, then assert rstn=0 in the response cycle -> b_rvalid drops immediately; after release, no stale response and last=0.
- Idle cycles, both valid=0 -> mem_valid=0, mem_write=0, and no rvalid.

Source files
------------

// File: rtl/mem36_arbiter.sv
// Two-port arbiter in front of a single-ported, registered-read 36-bit memory.
// Port A (fetch) and port B (load/store) share the memory; the policy is
// round-robin or A-priority with a bounded B starvation window.
module mem36_arbiter #(
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned PRIO_A   = 0,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_write,
  input  logic [3:0]       a_wmask,
  input  logic [35:0]      a_wdata,
  input  logic [WIDTH-1:0] a_addr,
  output logic             a_rvalid,
  output logic [35:0]      a_rdata,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_write,
  input  logic [3:0]       b_wmask,
  input  logic [35:0]      b_wdata,
  input  logic [WIDTH-1:0] b_addr,
  output logic             b_rvalid,
  output logic [35:0]      b_rdata,
  output logic             mem_valid,
  output logic             mem_write,
  output logic [3:0]       mem_wmask,
  output logic [35:0]      mem_wdata,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [35:0]      mem_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  logic          last_q;   // last granted port: 0 = A, 1 = B
  logic [CW-1:0] wait_q;   // consecutive refused B cycles
  logic          rd_a_q;
  logic          rd_b_q;
  logic          gnt_a;
  logic          gnt_b;
  logic          force_b;

  // Grant decision; depends only on valids and internal state, never on rdata
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    force_b = b_valid && (wait_q == WAIT_LIM);
    if (rstn) begin
      if (PRIO_A == 0) begin
        gnt_a = a_valid && (!b_valid || last_q);
      end else begin
        gnt_a = a_valid && !force_b;
      end
      gnt_b = b_valid && !gnt_a;
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // Memory port mux; with no grant the address/data idle on A's fields
  always_comb begin
    mem_valid = gnt_a || gnt_b;
    mem_write = 1'b0;
    mem_wmask = '0;
    mem_addr  = a_addr;
    mem_wdata = a_wdata;
    if (gnt_b) begin
      mem_write = b_write;
      mem_wmask = b_wmask;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end else if (gnt_a) begin
      mem_write = a_write;
      mem_wmask = a_wmask;
    end
  end

  // Round-robin history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 1'b0;
    end else if (gnt_a) begin
      last_q <= 1'b0;
    end else if (gnt_b) begin
      last_q <= 1'b1;
    end
  end

  // B starvation counter, saturating at the limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= '0;
    end else if (!b_valid || gnt_b) begin
      wait_q <= '0;
    end else if (wait_q != WAIT_LIM) begin
      wait_q <= wait_q + CW'(1);
    end
  end

  // Remember which port owns the read data arriving next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_a_q <= 1'b0;
      rd_b_q <= 1'b0;
    end else begin
      rd_a_q <= gnt_a && !a_write;
      rd_b_q <= gnt_b && !b_write;
    end
  end

  assign a_rvalid = rd_a_q;
  assign b_rvalid = rd_b_q;
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem36_arbiter.sv
// Bench for mem36_arbiter: a round-robin and an A-priority instance share one
// stimulus stream, each with its own registered-read memory; expected reads
// are queued at grant time and consumed when rvalid appears.
module tb_mem36_arbiter;

  localparam int unsigned WIDTH = 13;
  localparam int unsigned DEPTH = 1 << WIDTH;
  localparam int unsigned MAXW  = 4;

  typedef struct {
    int          id;    // dut*2 + port (0 = A, 1 = B)
    logic [35:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             a_valid, a_write, b_valid, b_write;
  logic [3:0]       a_wmask, b_wmask;
  logic [35:0]      a_wdata, b_wdata;
  logic [WIDTH-1:0] a_addr, b_addr;

  logic             a_rdy [2];
  logic             b_rdy [2];
  logic             a_rv  [2];
  logic             b_rv  [2];
  logic [35:0]      a_rd  [2];
  logic [35:0]      b_rd  [2];
  logic             mv    [2];
  logic             mw    [2];
  logic [3:0]       mm    [2];
  logic [35:0]      mwd   [2];
  logic [WIDTH-1:0] ma    [2];
  logic [35:0]      mrd   [2];

  logic [35:0] mem  [2][DEPTH];
  logic [35:0] refm [DEPTH];

  logic       m_last [2];
  logic [3:0] m_wait [2];
  logic       m_pa   [2];
  logic       m_pb   [2];
  exp_t       sbq[$];
  string      dn [2] = '{"rr", "pr"};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem36_arbiter #(.WIDTH(WIDTH), .PRIO_A(0), .MAX_WAIT(MAXW)) u_rr (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_ready(a_rdy[0]), .a_write(a_write), .a_wmask(a_wmask),
    .a_wdata(a_wdata), .a_addr(a_addr), .a_rvalid(a_rv[0]), .a_rdata(a_rd[0]),
    .b_valid(b_valid), .b_ready(b_rdy[0]), .b_write(b_write), .b_wmask(b_wmask),
    .b_wdata(b_wdata), .b_addr(b_addr), .b_rvalid(b_rv[0]), .b_rdata(b_rd[0]),
    .mem_valid(mv[0]), .mem_write(mw[0]), .mem_wmask(mm[0]), .mem_wdata(mwd[0]),
    .mem_addr(ma[0]), .mem_rdata(mrd[0])
  );

  mem36_arbiter #(.WIDTH(WIDTH), .PRIO_A(1), .MAX_WAIT(MAXW)) u_pr (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_ready(a_rdy[1]), .a_write(a_write), .a_wmask(a_wmask),
    .a_wdata(a_wdata), .a_addr(a_addr), .a_rvalid(a_rv[1]), .a_rdata(a_rd[1]),
    .b_valid(b_valid), .b_ready(b_rdy[1]), .b_write(b_write), .b_wmask(b_wmask),
    .b_wdata(b_wdata), .b_addr(b_addr), .b_rvalid(b_rv[1]), .b_rdata(b_rd[1]),
    .mem_valid(mv[1]), .mem_write(mw[1]), .mem_wmask(mm[1]), .mem_wdata(mwd[1]),
    .mem_addr(ma[1]), .mem_rdata(mrd[1])
  );

  // Registered-read memories, tag bits always written
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mv[d]) begin
        if (mw[d]) begin
          mem[d][ma[d]][35:32] <= mwd[d][35:32];
          for (int k = 0; k < 4; k++)
            if (mm[d][k]) mem[d][ma[d]][8*k +: 8] <= mwd[d][8*k +: 8];
        end else begin
          mrd[d] <= mem[d][ma[d]];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consume the oldest expected response for this dut/port
  task automatic pop_chk(input int id, input logic [35:0] obs, input string tag);
    int idx = -1;
    foreach (sbq[i]) if (idx < 0 && sbq[i].id == id) idx = i;
    checks++;
    assert (idx >= 0) else begin
      errors++;
      $error("FAIL %s observed=%h expected=no_response", tag, obs);
    end
    if (idx >= 0) begin
      chk(tag, obs, sbq[idx].data);
      sbq.delete(idx);
    end
  endtask

  // Reference arbitration per policy
  function automatic void model_gnt(input int d, output logic ga, output logic gb);
    ga = 1'b0;
    gb = 1'b0;
    if (rstn) begin
      if (d == 0) begin
        case ({a_valid, b_valid})
          2'b10:   ga = 1'b1;
          2'b01:   gb = 1'b1;
          2'b11:   begin ga = m_last[0]; gb = !m_last[0]; end
          default: ;
        endcase
      end else begin
        if (b_valid && m_wait[1] == 4'(MAXW)) gb = 1'b1;
        else if (a_valid)                     ga = 1'b1;
        else                                  gb = b_valid;
      end
    end
  endfunction

  function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] wd,
                                        input logic [3:0] wm);
    logic [35:0] r = old;
    r[35:32] = wd[35:32];
    for (int k = 0; k < 4; k++) if (wm[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // One clock: check at the falling edge, advance the model, return just after the rising edge
  task automatic tick();
    logic ga, gb;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_gnt(d, ga, gb);
      chk($sformatf("%s a_ready", dn[d]), 36'(a_rdy[d]), 36'(ga));
      chk($sformatf("%s b_ready", dn[d]), 36'(b_rdy[d]), 36'(gb));
      chk($sformatf("%s mem_valid", dn[d]), 36'(mv[d]), 36'(ga || gb));
      chk($sformatf("%s mem_write", dn[d]), 36'(mw[d]), 36'(ga ? a_write : (gb ? b_write : 1'b0)));
      chk($sformatf("%s mem_wmask", dn[d]), 36'(mm[d]), 36'(ga ? a_wmask : (gb ? b_wmask : 4'h0)));
      chk($sformatf("%s mem_addr", dn[d]), 36'(ma[d]), 36'(gb ? b_addr : a_addr));
      chk($sformatf("%s mem_wdata", dn[d]), mwd[d], gb ? b_wdata : a_wdata);
      chk($sformatf("%s a_rvalid", dn[d]), 36'(a_rv[d]), 36'(m_pa[d]));
      chk($sformatf("%s b_rvalid", dn[d]), 36'(b_rv[d]), 36'(m_pb[d]));
      if (a_rv[d]) pop_chk(d * 2,     a_rd[d], $sformatf("%s a_rdata", dn[d]));
      if (b_rv[d]) pop_chk(d * 2 + 1, b_rd[d], $sformatf("%s b_rdata", dn[d]));
      m_pa[d] = ga && !a_write;
      m_pb[d] = gb && !b_write;
      if (m_pa[d]) sbq.push_back('{d * 2, refm[a_addr]});
      if (m_pb[d]) sbq.push_back('{d * 2 + 1, refm[b_addr]});
      if (rstn) begin
        if (ga) m_last[d] = 1'b0;
        else if (gb) m_last[d] = 1'b1;
        if (gb || !b_valid) m_wait[d] = 4'h0;
        else if (m_wait[d] != 4'(MAXW)) m_wait[d] = m_wait[d] + 4'h1;
      end
    end
    // Both instances see identical writes in this bench, so one reference suffices
    model_gnt(0, ga, gb);
    if (ga && a_write) refm[a_addr] = merge(refm[a_addr], a_wdata, a_wmask);
    if (gb && b_write) refm[b_addr] = merge(refm[b_addr], b_wdata, b_wmask);
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle: responses vanish immediately, pending reads are dropped
  task automatic reset_now();
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s a_rvalid in reset", dn[d]), 36'(a_rv[d]), 36'h0);
      chk($sformatf("%s b_rvalid in reset", dn[d]), 36'(b_rv[d]), 36'h0);
      m_last[d] = 1'b0;
      m_wait[d] = 4'h0;
      m_pa[d]   = 1'b0;
      m_pb[d]   = 1'b0;
    end
    sbq.delete();
  endtask

  task automatic set_a(input logic v, input logic w, input logic [3:0] m,
                       input logic [35:0] dat, input logic [WIDTH-1:0] ad);
    a_valid = v; a_write = w; a_wmask = m; a_wdata = dat; a_addr = ad;
  endtask

  task automatic set_b(input logic v, input logic w, input logic [3:0] m,
                       input logic [35:0] dat, input logic [WIDTH-1:0] ad);
    b_valid = v; b_write = w; b_wmask = m; b_wdata = dat; b_addr = ad;
  endtask

  initial begin
    rstn = 1'b0;
    set_a(1'b0, 1'b0, 4'h0, 36'h0, '0);
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1'b0; m_wait[d] = 4'h0; m_pa[d] = 1'b0; m_pb[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset are never granted
    set_a(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    set_b(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    tick();
    set_a(1'b0, 1'b0, 4'h0, 36'h0, '0);
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    rstn = 1'b1;
    tick();

    // A full write then A read of the same word
    set_a(1'b1, 1'b1, 4'hF, 36'hF_DEADBEEF, 13'h010);
    tick();
    set_a(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    tick();
    set_a(1'b0, 1'b0, 4'h0, 36'h0, '0);
    tick();

    // B partial write: only byte 0 plus the tag change
    set_b(1'b1, 1'b1, 4'h1, 36'h3_00000011, 13'h010);
    tick();
    set_b(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    tick();
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    tick();

    // A write followed immediately by a B read of the same word
    set_a(1'b1, 1'b1, 4'hF, 36'h6_12345678, 13'h020);
    tick();
    set_a(1'b0, 1'b0, 4'h0, 36'h0, '0);
    set_b(1'b1, 1'b0, 4'h0, 36'h0, 13'h020);
    tick();
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    tick();

    // Idle with write-looking A fields: no strobe, no write, address/data follow A
    set_a(1'b0, 1'b1, 4'hF, 36'h9_99999999, 13'h1FF);
    repeat (2) tick();

    // Both ports reading continuously from a fresh reset
    reset_now();
    tick();
    rstn = 1'b1;
    set_a(1'b1, 1'b0, 4'h0, 36'h0, 13'h020);
    set_b(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    repeat (12) tick();
    set_a(1'b0, 1'b0, 4'h0, 36'h0, '0);
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    repeat (2) tick();

    // B read granted, reset lands in its response cycle
    set_b(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    tick();
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    reset_now();
    set_a(1'b1, 1'b0, 4'h0, 36'h0, 13'h020);
    set_b(1'b1, 1'b0, 4'h0, 36'h0, 13'h010);
    tick();
    rstn = 1'b1;
    tick();
    set_a(1'b0, 1'b0, 4'h0, 36'h0, '0);
    set_b(1'b0, 1'b0, 4'h0, 36'h0, '0);
    repeat (2) tick();

    chk("scoreboard drained", 36'(sbq.size()), 36'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
